// File: rtl/sid_pkg.sv
// Shared definitions for the SID 8580 voice oscillator.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
//
// Holds control-register bit positions, noise LFSR geometry/seed/taps,
// the noise output tap order and the 12-bit raw wave type.
package sid_pkg;

  // Voice control register bit positions
  localparam int CTL_NOISE = 7;
  localparam int CTL_PULSE = 6;
  localparam int CTL_SAW   = 5;
  localparam int CTL_TRI   = 4;
  localparam int CTL_TEST  = 3;
  localparam int CTL_RING  = 2;
  localparam int CTL_SYNC  = 1;
  localparam int CTL_GATE  = 0;

  // Noise LFSR geometry
  localparam int               LFSR_W        = 23;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 23'h7FFFF8;
  localparam int               LFSR_FB_A     = 22;
  localparam int               LFSR_FB_B     = 17;

  // LFSR bits that drive noise_out[11:4], most significant first.
  // The same order maps combined_in[7:0] onto the LFSR during writeback.
  localparam int NOISE_TAP [8] = '{20, 18, 14, 11, 9, 5, 2, 0};

  typedef logic [11:0] wave_t;

  // Gather the eight noise taps into the top of a 12-bit wave value.
  function automatic wave_t noise_from_lfsr(input logic [LFSR_W-1:0] s);
    wave_t w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[11-i] = s[NOISE_TAP[i]];
    end
    return w;
  endfunction

endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit SID noise LFSR with optional per-bit writeback mask.
// Latency: state updates on the clock edge where ce is high.
// Backpressure: none; advances unconditionally on each ce.
//
// Ports: clock, reset_n (sync, active-low), ce (1 MHz enable),
//        clk_en (bit-19 rise of the accumulator on this ce),
//        test (hold at seed), wb_mask (AND mask applied after any shift),
//        lfsr (current state).
module sid_noise_lfsr
  import sid_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              clk_en,
  input  logic              test,
  input  logic [LFSR_W-1:0] wb_mask,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] shifted;

  always_comb begin
    shifted = lfsr;
    if (clk_en) begin
      shifted = {lfsr[LFSR_W-2:0], lfsr[LFSR_FB_A] ^ lfsr[LFSR_FB_B]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (ce) begin
      if (test) begin
        lfsr <= LFSR_SEED;
      end else begin
        // Mask is all-ones unless the combined-waveform lockup is active
        lfsr <= shifted & wb_mask;
      end
    end
  end

endmodule

// File: rtl/sid_oscillator.sv
// SID 8580 voice oscillator: phase accumulator, sync/ring coupling, noise LFSR.
// Latency: wave outputs valid one clock after the ce edge; sync_out registered.
// Backpressure: none; state advances on every ce_1m pulse.
//
// Ports: clock, reset_n (sync, active-low), ce_1m, freq[15:0], pw[11:0],
//        control[7:0], sync_in, ring_msb_in, combined_in[7:0] ->
//        acc_msb, sync_out, saw_out, tri_out, pulse_out, noise_out (12-bit).
// Optional build macro SID_OSC_NOISE_WRITEBACK_EN: combined waveform bits are
// ANDed back into the noise LFSR taps (8580 noise lockup); without it
// combined_in is ignored.
module sid_oscillator
  import sid_pkg::*;
#(
  parameter int                ACC_W     = 24,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic [15:0] freq,
  input  logic [11:0] pw,
  input  logic [7:0]  control,
  input  logic        sync_in,
  input  logic        ring_msb_in,
  input  logic [7:0]  combined_in,
  output logic        acc_msb,
  output logic        sync_out,
  output logic [11:0] saw_out,
  output logic [11:0] tri_out,
  output logic [11:0] pulse_out,
  output logic [11:0] noise_out
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic              sync_q;
  logic              test_bit;
  logic              lfsr_clk;
  logic              tri_invert;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] wb_mask;

  assign test_bit = control[CTL_TEST];

  // Test beats hard sync beats the normal add; both force the phase to zero
  always_comb begin
    acc_next = acc + {{(ACC_W-16){1'b0}}, freq};
    if (test_bit) begin
      acc_next = '0;
    end else if (control[CTL_SYNC] && sync_in) begin
      acc_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc    <= '0;
      sync_q <= 1'b0;
    end else if (ce_1m) begin
      acc    <= acc_next;
      // A forced zero can never raise the MSB, so resets never emit a pulse
      sync_q <= ~acc[ACC_W-1] & acc_next[ACC_W-1];
    end else begin
      sync_q <= 1'b0;
    end
  end

  // Noise clock: accumulator bit 19 rising across this update
  assign lfsr_clk = ~test_bit & ~acc[ACC_W-5] & acc_next[ACC_W-5];

`ifdef SID_OSC_NOISE_WRITEBACK_EN
  always_comb begin
    wb_mask = '1;
    if (control[CTL_NOISE] && !test_bit &&
        (control[CTL_PULSE] || control[CTL_SAW] || control[CTL_TRI])) begin
      for (int i = 0; i < 8; i++) begin
        wb_mask[NOISE_TAP[i]] = combined_in[7-i];
      end
    end
  end
  logic unused_ok;
  assign unused_ok = &{1'b0, control[CTL_GATE]};
`else
  assign wb_mask = '1;
  logic unused_ok;
  assign unused_ok = &{1'b0, control[CTL_GATE], combined_in};
`endif

  sid_noise_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_noise (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce_1m),
    .clk_en  (lfsr_clk),
    .test    (test_bit),
    .wb_mask (wb_mask),
    .lfsr    (lfsr)
  );

  // Ring mod swaps the triangle fold source with the previous voice's MSB
  assign tri_invert = acc[ACC_W-1] ^ (control[CTL_RING] & ring_msb_in);

  assign acc_msb   = acc[ACC_W-1];
  assign sync_out  = sync_q;
  assign saw_out   = acc[ACC_W-1 -: 12];
  assign tri_out   = acc[ACC_W-2 -: 12] ^ {12{tri_invert}};
  assign pulse_out = (test_bit || (saw_out >= pw)) ? 12'hFFF : 12'h000;
  assign noise_out = noise_from_lfsr(lfsr);

endmodule

// File: tb/tb_sid_oscillator.sv
module tb_sid_oscillator;

  logic        clock;
  logic        reset_n;
  logic        ce_1m;
  logic [15:0] freq;
  logic [11:0] pw;
  logic [7:0]  control;
  logic        sync_in;
  logic        ring_msb_in;
  logic [7:0]  combined_in;
  logic        acc_msb;
  logic        sync_out;
  logic [11:0] saw_out;
  logic [11:0] tri_out;
  logic [11:0] pulse_out;
  logic [11:0] noise_out;

  int n_cmp  = 0;
  int n_fail = 0;

  sid_oscillator dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ce_1m       (ce_1m),
    .freq        (freq),
    .pw          (pw),
    .control     (control),
    .sync_in     (sync_in),
    .ring_msb_in (ring_msb_in),
    .combined_in (combined_in),
    .acc_msb     (acc_msb),
    .sync_out    (sync_out),
    .saw_out     (saw_out),
    .tri_out     (tri_out),
    .pulse_out   (pulse_out),
    .noise_out   (noise_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [7:0]  ctl;
    logic [15:0] freq;
    logic [11:0] pw;
    logic        ring;
    int          n_ce;
    logic [11:0] saw;
    logic [11:0] tri_w;
    logic [11:0] pulse;
    logic [11:0] noise;
    logic        msb;
    int          syncs;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ce_1m   = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ce_1m held high for n consecutive clocks; counts sync_out pulses seen
  task automatic run_ce(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      ce_1m = 1'b1;
      @(posedge clock);
      #1;
      if (sync_out) pulses++;
    end
    ce_1m = 1'b0;
  endtask

  initial begin
    int p;

    reset_n     = 1'b1;
    ce_1m       = 1'b0;
    freq        = '0;
    pw          = '0;
    control     = '0;
    sync_in     = 1'b0;
    ring_msb_in = 1'b0;
    combined_in = 8'hFF;

    //            rst ctl    freq      pw      ring n    saw      tri      pulse    noise    msb syncs
    vecs[0]  = '{1'b1, 8'h00, 16'h0000, 12'h001, 1'b0, 0,   12'h000, 12'h000, 12'h000, 12'hFC0, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'h00, 16'h0100, 12'h001, 1'b0, 256, 12'h010, 12'h020, 12'hFFF, 12'hFC0, 1'b0, 0};
    vecs[2]  = '{1'b0, 8'h00, 16'h0000, 12'h001, 1'b0, 5,   12'h010, 12'h020, 12'hFFF, 12'hFC0, 1'b0, 0};
    vecs[3]  = '{1'b1, 8'h80, 16'h8000, 12'h800, 1'b0, 32,  12'h100, 12'h200, 12'h000, 12'hFC0, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'h80, 16'h8000, 12'h800, 1'b0, 64,  12'h300, 12'h600, 12'h000, 12'hF80, 1'b0, 0};
    vecs[5]  = '{1'b0, 8'h88, 16'h8000, 12'h800, 1'b0, 1,   12'h000, 12'h000, 12'hFFF, 12'hFC0, 1'b0, 0};
    vecs[6]  = '{1'b1, 8'h04, 16'h0000, 12'h800, 1'b1, 0,   12'h000, 12'hFFF, 12'h000, 12'hFC0, 1'b0, 0};
    vecs[7]  = '{1'b0, 8'h04, 16'h0000, 12'h800, 1'b0, 0,   12'h000, 12'h000, 12'h000, 12'hFC0, 1'b0, 0};
    vecs[8]  = '{1'b1, 8'h00, 16'h8000, 12'h800, 1'b0, 256, 12'h800, 12'hFFF, 12'hFFF, 12'hF00, 1'b1, 1};
    vecs[9]  = '{1'b0, 8'h04, 16'h8000, 12'h800, 1'b1, 0,   12'h800, 12'h000, 12'hFFF, 12'hF00, 1'b1, 0};
    vecs[10] = '{1'b0, 8'h00, 16'h8000, 12'h800, 1'b0, 256, 12'h000, 12'h000, 12'h000, 12'h810, 1'b0, 0};

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst) do_reset();
      control     = vecs[v].ctl;
      freq        = vecs[v].freq;
      pw          = vecs[v].pw;
      ring_msb_in = vecs[v].ring;
      #1;
      run_ce(vecs[v].n_ce, p);
      check($sformatf("v%0d saw", v),   saw_out,   vecs[v].saw);
      check($sformatf("v%0d tri", v),   tri_out,   vecs[v].tri_w);
      check($sformatf("v%0d pulse", v), pulse_out, vecs[v].pulse);
      check($sformatf("v%0d noise", v), noise_out, vecs[v].noise);
      check($sformatf("v%0d msb", v),   acc_msb,   vecs[v].msb);
      check($sformatf("v%0d syncs", v), p,         vecs[v].syncs);
    end
    ring_msb_in = 1'b0;

    // MSB crossing: pulse comparator edge and one-clock sync_out
    do_reset();
    control = 8'h40;
    freq    = 16'h8000;
    pw      = 12'h800;
    run_ce(255, p);
    check("msb pre saw", saw_out, 12'h7F8);
    check("msb pre pulse", pulse_out, 12'h000);
    check("msb pre syncs", p, 0);
    run_ce(1, p);
    check("msb saw", saw_out, 12'h800);
    check("msb pulse", pulse_out, 12'hFFF);
    check("msb sync_out", sync_out, 1'b1);
    @(posedge clock);
    #1;
    check("msb sync_out drop", sync_out, 1'b0);

    // Hard sync from the previous voice, and sync_in ignored without sync bit
    do_reset();
    control = 8'h02;
    freq    = 16'h1000;
    run_ce(9, p);
    check("hsync pre saw", saw_out, 12'h009);
    sync_in = 1'b1;
    run_ce(1, p);
    sync_in = 1'b0;
    check("hsync saw", saw_out, 12'h000);
    check("hsync sync_out", sync_out, 1'b0);
    control = 8'h00;
    sync_in = 1'b1;
    run_ce(1, p);
    sync_in = 1'b0;
    check("nosync saw", saw_out, 12'h001);
    repeat (3) @(posedge clock);
    #1;
    check("idle hold saw", saw_out, 12'h001);

    // Reset coincident with ce at the edge that would raise the MSB
    do_reset();
    control = 8'h00;
    freq    = 16'h8000;
    run_ce(255, p);
    check("rst pre noise", noise_out, 12'hF00);
    reset_n = 1'b0;
    ce_1m   = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ce_1m   = 1'b0;
    check("rst saw", saw_out, 12'h000);
    check("rst msb", acc_msb, 1'b0);
    check("rst noise", noise_out, 12'hFC0);
    check("rst sync_out", sync_out, 1'b0);

    // Noise + saw with an all-zero combined value
    do_reset();
    control     = 8'hA0;
    freq        = 16'h0001;
    combined_in = 8'h00;
    run_ce(1, p);
`ifdef SID_OSC_NOISE_WRITEBACK_EN
    check("wb noise", noise_out, 12'h000);
`else
    check("wb noise", noise_out, 12'hFC0);
`endif
    combined_in = 8'hFF;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
